// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner with per-key debounce and a press/release event FIFO.
// Columns are driven one-hot; each key is debounced on its column's sample cycle.
module keypad_scan_fifo #(
    parameter int N_COLS     = 4,
    parameter int N_ROWS     = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE   = 3,
    parameter int FIFO_DEPTH = 4,
    localparam int CW        = $clog2(N_COLS),
    localparam int RW        = $clog2(N_ROWS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [N_ROWS-1:0] filas,
    output logic [N_COLS-1:0] columnas,
    output logic              key_valid,
    input  logic              key_ready,
    output logic [CW+RW-1:0]  key_code,
    output logic              key_pressed,
    output logic              overflow
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int NK = N_COLS * N_ROWS;
    localparam int KW = $clog2(NK);
    localparam int BW = $clog2(DEBOUNCE + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = CW + RW + 1;

    logic [N_ROWS-1:0] sync1, sync2;
    logic              running;
    logic [CW-1:0]     col;
    logic [DW-1:0]     dwell;
    logic              sample;

    logic              db  [NK];
    logic [BW-1:0]     cnt [NK];
    logic [KW-1:0]     kidx    [N_ROWS];
    logic [BW-1:0]     nxt_cnt [N_ROWS];
    logic              ev;
    logic              ev_state;
    logic [RW-1:0]     win;

    logic [EW-1:0]     mem [FIFO_DEPTH];
    logic [AW:0]       wp, rp;
    logic              empty, full, pop, push;

    assign sample = running && (dwell == DW'(SCAN_DIV - 1));

    // two-flop synchroniser for the asynchronous row inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= filas;
            sync2 <= sync1;
        end
    end

    // column scan: dwell counter and column index, restarted whenever enable drops
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            running <= 1'b0;
            col     <= '0;
            dwell   <= '0;
        end else begin
            running <= 1'b1;
            if (running) begin
                if (sample) begin
                    dwell <= '0;
                    col   <= (col == CW'(N_COLS - 1)) ? '0 : col + 1'b1;
                end else begin
                    dwell <= dwell + 1'b1;
                end
            end
        end
    end

    assign columnas = running ? ({{(N_COLS-1){1'b0}}, 1'b1} << col) : '0;

    // next debounce counts for the current column and lowest-row winner
    always_comb begin
        ev       = 1'b0;
        ev_state = 1'b0;
        win      = '0;
        for (int r = 0; r < N_ROWS; r++) begin
            kidx[r] = KW'(int'(col) * N_ROWS + r);
            if (sync2[r] == db[kidx[r]])
                nxt_cnt[r] = '0;
            else if (cnt[kidx[r]] == BW'(DEBOUNCE))
                nxt_cnt[r] = cnt[kidx[r]];
            else
                nxt_cnt[r] = cnt[kidx[r]] + 1'b1;
        end
        for (int r = N_ROWS - 1; r >= 0; r--) begin
            if (nxt_cnt[r] == BW'(DEBOUNCE)) begin
                ev       = 1'b1;
                win      = RW'(r);
                ev_state = ~db[kidx[r]];
            end
        end
    end

    // per-key debounce state, updated only for the column being sampled
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NK; k++) begin
                db[k]  <= 1'b0;
                cnt[k] <= '0;
            end
        end else if (sample) begin
            for (int r = 0; r < N_ROWS; r++) begin
                if (ev && win == RW'(r)) begin
                    db[kidx[r]]  <= ~db[kidx[r]];
                    cnt[kidx[r]] <= '0;
                end else begin
                    cnt[kidx[r]] <= nxt_cnt[r];
                end
            end
        end
    end

    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign pop   = key_valid && key_ready;
    assign push  = sample && ev && (!full || pop);

    // FIFO pointers and sticky overflow; a pop frees the slot for a same-cycle push
    always_ff @(posedge clk) begin
        if (reset) begin
            wp       <= '0;
            rp       <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
            if (sample && ev && full && !pop)
                overflow <= 1'b1;
        end
    end

    // FIFO storage, written at the tail on an accepted event
    always_ff @(posedge clk) begin
        if (push)
            mem[wp[AW-1:0]] <= {col, win, ev_state};
    end

    assign key_valid   = !empty;
    assign key_code    = key_valid ? mem[rp[AW-1:0]][EW-1:1] : '0;
    assign key_pressed = key_valid ? mem[rp[AW-1:0]][0] : 1'b0;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Randomised scoreboard bench for keypad_scan_fifo.
// A visit-level keypad model predicts events; a monitor compares outputs.
module tb_keypad_scan_fifo;

    localparam int NC = 4;
    localparam int NR = 4;
    localparam int SD = 8;
    localparam int DB = 3;
    localparam int FD = 4;

    logic       clk = 1'b0;
    logic       reset, enable, key_ready;
    logic [3:0] filas, columnas, key_code;
    logic       key_valid, key_pressed, overflow;

    always #5 clk = ~clk;

    keypad_scan_fifo #(
        .N_COLS(NC), .N_ROWS(NR), .SCAN_DIV(SD),
        .DEBOUNCE(DB), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .filas(filas),
        .columnas(columnas), .key_valid(key_valid), .key_ready(key_ready),
        .key_code(key_code), .key_pressed(key_pressed), .overflow(overflow)
    );

    // physical key matrix: keys[c][r] closed connects column c to row r
    logic [3:0] keys [NC];

    always_comb begin
        filas = '0;
        for (int c = 0; c < NC; c++)
            if (columnas[c] === 1'b1) filas = filas | keys[c];
    end

    typedef struct {
        logic [3:0] code;
        bit         pr;
    } ev_t;

    ev_t sb[$];
    int  vectors = 0;
    int  miscompares = 0;
    bit  checking = 0;

    bit  m_run;
    int  m_n;
    bit  m_db  [NC][NR];
    int  m_cnt [NC][NR];
    int  m_occ;
    bit  m_ovf;

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: keypad visits, debounce rule and event queue occupancy
    always @(posedge clk) begin : model
        int  c, win;
        bit  pop, room;
        ev_t e;
        if (reset) begin
            for (int i = 0; i < NC; i++)
                for (int j = 0; j < NR; j++) begin
                    m_db[i][j]  = 0;
                    m_cnt[i][j] = 0;
                end
            m_run = 0;
            m_n   = 0;
            m_occ = 0;
            m_ovf = 0;
            sb.delete();
        end else begin
            pop  = (m_occ > 0) && key_ready;
            room = (m_occ < FD) || pop;
            if (pop) m_occ--;
            if (m_run && (m_n % SD) == SD - 1) begin
                c   = (m_n / SD) % NC;
                win = -1;
                for (int r = 0; r < NR; r++) begin
                    if (keys[c][r] == m_db[c][r]) m_cnt[c][r] = 0;
                    else if (m_cnt[c][r] < DB) m_cnt[c][r]++;
                end
                for (int r = 0; r < NR; r++)
                    if (win < 0 && m_cnt[c][r] == DB) win = r;
                if (win >= 0) begin
                    m_db[c][win]  = !m_db[c][win];
                    m_cnt[c][win] = 0;
                    e.code = 4'(c * NR + win);
                    e.pr   = m_db[c][win];
                    if (room) begin
                        sb.push_back(e);
                        m_occ++;
                    end else begin
                        m_ovf = 1;
                    end
                end
            end
            if (enable) begin
                m_n   = m_run ? m_n + 1 : 0;
                m_run = 1;
            end else begin
                m_run = 0;
                m_n   = 0;
            end
        end
    end

    // monitor: compares DUT outputs against the model on the falling edge
    always @(negedge clk) begin : monitor
        logic [3:0] exp_col;
        if (checking) begin
            exp_col = m_run ? 4'(1 << ((m_n / SD) % NC)) : 4'd0;
            chk("columnas", int'(columnas), int'(exp_col));
            chk("key_valid", int'(key_valid), int'(sb.size() > 0));
            chk("overflow", int'(overflow), int'(m_ovf));
            if (sb.size() > 0) begin
                chk("key_code", int'(key_code), int'(sb[0].code));
                chk("key_pressed", int'(key_pressed), int'(sb[0].pr));
                if (key_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic at_col_start();
        bit ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (!m_run || (m_n % SD) == 0) ok = 1;
            else cyc(1);
        end
        chk("col_start_wait", int'(ok), 1);
    endtask

    task automatic wait_sample(int c);
        bit ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (m_run && (m_n % SD) == SD - 1 && ((m_n / SD) % NC) == c) ok = 1;
            else cyc(1);
        end
        chk("sample_wait", int'(ok), 1);
    endtask

    task automatic do_reset();
        reset = 1;
        cyc(2);
        reset = 0;
    endtask

    initial begin
        for (int c = 0; c < NC; c++) keys[c] = '0;
        reset     = 1;
        enable    = 0;
        key_ready = 1;
        cyc(2);
        checking = 1;
        cyc(1);
        chk("reset_valid", int'(key_valid), 0);
        chk("reset_code", int'(key_code), 0);
        chk("reset_cols", int'(columnas), 0);
        reset  = 0;
        enable = 1;
        cyc(40);

        at_col_start();
        keys[1][2] = 1;
        cyc(32 * 4);
        at_col_start();
        keys[1][2] = 0;
        cyc(32 * 4);

        at_col_start();
        keys[0][1] = 1;
        cyc(64);
        at_col_start();
        keys[0][1] = 0;
        cyc(128);

        at_col_start();
        keys[2][0] = 1;
        keys[2][3] = 1;
        cyc(32 * 6);
        at_col_start();
        keys[2][0] = 0;
        keys[2][3] = 0;
        cyc(32 * 6);

        do_reset();
        key_ready = 0;
        at_col_start();
        keys[0] = 4'hF;
        cyc(32 * 8);
        at_col_start();
        keys[1][0] = 1;
        wait_sample(1);
        cyc(1);
        wait_sample(1);
        cyc(1);
        wait_sample(1);
        key_ready = 1;
        cyc(1);
        key_ready = 0;
        cyc(4);
        chk("full_pop_push_no_ovf", int'(overflow), 0);
        at_col_start();
        keys[1][1] = 1;
        cyc(32 * 4);
        chk("ovf_sticky", int'(overflow), 1);
        key_ready = 1;
        cyc(20);

        for (int i = 0; i < 40 && (m_n % SD) != 3; i++) cyc(1);
        enable = 0;
        cyc(5);
        enable = 1;
        cyc(20);

        key_ready = 0;
        at_col_start();
        keys[3][0] = 1;
        keys[3][1] = 1;
        cyc(32 * 5);
        reset = 1;
        cyc(1);
        reset = 0;
        chk("reset_flush", int'(key_valid), 0);
        key_ready = 1;
        cyc(10);

        for (int i = 0; i < 3000; i++) begin
            if ((!m_run || (m_n % SD) == 0) && ($urandom % 4) == 0)
                keys[$urandom % NC][$urandom % NR] ^= 1'b1;
            key_ready = ($urandom % 4) != 0;
            if (($urandom % 400) == 0) enable = !enable;
            cyc(1);
        end
        enable    = 1;
        key_ready = 1;
        cyc(50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
